// File: rtl/bpu_ctrl.sv
// Branch prediction bookkeeping: queues fetch-time predictions, checks them at
// resolution, drives predictor updates, misprediction recovery and statistics.
module bpu_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallF,
  input  logic             BranchF,
  input  logic             BP,
  input  logic [31:0]      PCF,
  input  logic             BranchB,
  input  logic             ZeroB,
  input  logic [31:0]      PCB,
  input  logic [31:0]      PCTargetB,
  output logic             UpdateEn,
  output logic             UpdateTaken,
  output logic [31:0]      UpdatePC,
  output logic             Flush,
  output logic             RedirectEn,
  output logic [31:0]      RedirectPC,
  output logic             Full,
  output logic             Err,
  output logic [CNT_W-1:0] BrCount,
  output logic [CNT_W-1:0] MissCount
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef enum logic {RUN, RECOVER} state_t;

  state_t           state, state_next;
  logic [PTR_W-1:0] head, tail;
  logic [OCC_W-1:0] occ;
  logic             rec_bp [DEPTH];
  logic [31:0]      rec_pc [DEPTH];

  logic run, deq, mispredict, enq, overflow, empty_res, pc_mismatch;

  assign run         = (state == RUN);
  assign Full        = (occ == OCC_W'(DEPTH));
  assign deq         = BranchB & run & (occ != '0);
  assign mispredict  = deq & (rec_bp[head] != ZeroB);
  // A dequeue frees a slot in the same cycle, so a full queue may still accept.
  assign enq         = BranchF & ~StallF & run & (~Full | deq) & ~mispredict;
  assign overflow    = BranchF & ~StallF & run & Full & ~deq;
  assign empty_res   = BranchB & run & (occ == '0);
  assign pc_mismatch = deq & (rec_pc[head] != PCB);

  always_ff @(posedge clk) begin
    if (enq) begin
      rec_bp[tail] <= BP;
      rec_pc[tail] <= PCF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      head        <= '0;
      tail        <= '0;
      occ         <= '0;
      UpdateEn    <= 1'b0;
      UpdateTaken <= 1'b0;
      UpdatePC    <= '0;
      RedirectPC  <= '0;
      Err         <= 1'b0;
      BrCount     <= '0;
      MissCount   <= '0;
    end else begin
      state    <= state_next;
      UpdateEn <= deq;
      if (deq) begin
        UpdateTaken <= ZeroB;
        UpdatePC    <= PCB;
      end
      if (mispredict)
        RedirectPC <= ZeroB ? PCTargetB : PCB + 32'd4;
      if (overflow | empty_res | pc_mismatch)
        Err <= 1'b1;
      if (deq && BrCount != '1)
        BrCount <= BrCount + CNT_W'(1);
      if (mispredict && MissCount != '1)
        MissCount <= MissCount + CNT_W'(1);
      // Wrong-path records are discarded as soon as the mispredict is seen.
      if (mispredict || !run) begin
        head <= '0;
        tail <= '0;
        occ  <= '0;
      end else begin
        if (enq) tail <= tail + PTR_W'(1);
        if (deq) head <= head + PTR_W'(1);
        if (enq && !deq)      occ <= occ + OCC_W'(1);
        else if (!enq && deq) occ <= occ - OCC_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    Flush      = 1'b0;
    RedirectEn = 1'b0;
    case (state)
      RUN: begin
        if (mispredict) state_next = RECOVER;
      end
      RECOVER: begin
        Flush      = 1'b1;
        RedirectEn = 1'b1;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

endmodule

// File: tb/tb_bpu_ctrl.sv
// Directed self-checking bench for bpu_ctrl; a second instance with 4-bit
// counters shares the stimulus to exercise counter saturation.
module tb_bpu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StallF = 1'b0, BranchF = 1'b0, BP = 1'b0;
  logic [31:0] PCF = '0;
  logic        BranchB = 1'b0, ZeroB = 1'b0;
  logic [31:0] PCB = '0, PCTargetB = '0;

  logic        UpdateEn, UpdateTaken, Flush, RedirectEn, Full, Err;
  logic [31:0] UpdatePC, RedirectPC;
  logic [15:0] BrCount, MissCount;

  logic        UpdateEn4, UpdateTaken4, Flush4, RedirectEn4, Full4, Err4;
  logic [31:0] UpdatePC4, RedirectPC4;
  logic [3:0]  BrCount4, MissCount4;

  int checks = 0;
  int failures = 0;
  int exp_br = 0;
  int exp_miss = 0;

  always #5 clk = ~clk;

  bpu_ctrl #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .BranchF(BranchF), .BP(BP),
    .PCF(PCF), .BranchB(BranchB), .ZeroB(ZeroB), .PCB(PCB), .PCTargetB(PCTargetB),
    .UpdateEn(UpdateEn), .UpdateTaken(UpdateTaken), .UpdatePC(UpdatePC),
    .Flush(Flush), .RedirectEn(RedirectEn), .RedirectPC(RedirectPC),
    .Full(Full), .Err(Err), .BrCount(BrCount), .MissCount(MissCount)
  );

  bpu_ctrl #(.DEPTH(4), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .StallF(StallF), .BranchF(BranchF), .BP(BP),
    .PCF(PCF), .BranchB(BranchB), .ZeroB(ZeroB), .PCB(PCB), .PCTargetB(PCTargetB),
    .UpdateEn(UpdateEn4), .UpdateTaken(UpdateTaken4), .UpdatePC(UpdatePC4),
    .Flush(Flush4), .RedirectEn(RedirectEn4), .RedirectPC(RedirectPC4),
    .Full(Full4), .Err(Err4), .BrCount(BrCount4), .MissCount(MissCount4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, sample 1 time unit after the edge, then go idle.
  task automatic applyStimulus(input logic brf, input logic bpv, input logic [31:0] pcf,
                               input logic brb, input logic zb, input logic [31:0] pcb,
                               input logic [31:0] tgt);
    BranchF = brf; BP = bpv; PCF = pcf;
    BranchB = brb; ZeroB = zb; PCB = pcb; PCTargetB = tgt;
    @(posedge clk); #1;
    BranchF = 1'b0; BP = 1'b0; PCF = '0;
    BranchB = 1'b0; ZeroB = 1'b0; PCB = '0; PCTargetB = '0;
  endtask

  task automatic enqueue(input logic [31:0] pc, input logic bpv);
    applyStimulus(1'b1, bpv, pc, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic zb, input logic [31:0] tgt);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, zb, pc, tgt);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_br = 0;
    exp_miss = 0;
  endtask

  function automatic logic [31:0] sat4(input int v);
    return (v > 15) ? 32'd15 : 32'(v);
  endfunction

  initial begin
    @(posedge clk); #1;
    doReset();
    checkOutput("rst_full", {31'b0, Full}, 32'd0);
    checkOutput("rst_upd_en", {31'b0, UpdateEn}, 32'd0);
    checkOutput("rst_upd_taken", {31'b0, UpdateTaken}, 32'd0);
    checkOutput("rst_upd_pc", UpdatePC, 32'h0);
    checkOutput("rst_flush", {31'b0, Flush}, 32'd0);
    checkOutput("rst_redir_en", {31'b0, RedirectEn}, 32'd0);
    checkOutput("rst_redir_pc", RedirectPC, 32'h0);
    checkOutput("rst_err", {31'b0, Err}, 32'd0);
    checkOutput("rst_br", {16'b0, BrCount}, 32'd0);
    checkOutput("rst_miss", {16'b0, MissCount}, 32'd0);
    checkOutput("rst_br4", {28'b0, BrCount4}, 32'd0);

    // Correctly predicted taken branch
    enqueue(32'h10, 1'b1);
    resolve(32'h10, 1'b1, 32'h0);
    exp_br++;
    checkOutput("hit_upd_en", {31'b0, UpdateEn}, 32'd1);
    checkOutput("hit_upd_taken", {31'b0, UpdateTaken}, 32'd1);
    checkOutput("hit_upd_pc", UpdatePC, 32'h10);
    checkOutput("hit_flush", {31'b0, Flush}, 32'd0);
    checkOutput("hit_br", {16'b0, BrCount}, 32'(exp_br));
    checkOutput("hit_miss", {16'b0, MissCount}, 32'(exp_miss));
    idle();
    checkOutput("hit_upd_pulse", {31'b0, UpdateEn}, 32'd0);

    // Predicted not-taken, actually taken
    enqueue(32'h20, 1'b0);
    resolve(32'h20, 1'b1, 32'h80);
    exp_br++; exp_miss++;
    checkOutput("mp_flush", {31'b0, Flush}, 32'd1);
    checkOutput("mp_redir_en", {31'b0, RedirectEn}, 32'd1);
    checkOutput("mp_redir_pc", RedirectPC, 32'h80);
    checkOutput("mp_upd_en", {31'b0, UpdateEn}, 32'd1);
    checkOutput("mp_upd_taken", {31'b0, UpdateTaken}, 32'd1);
    checkOutput("mp_full", {31'b0, Full}, 32'd0);
    checkOutput("mp_miss", {16'b0, MissCount}, 32'(exp_miss));
    checkOutput("mp_br", {16'b0, BrCount}, 32'(exp_br));
    idle();
    checkOutput("mp_flush_end", {31'b0, Flush}, 32'd0);
    checkOutput("mp_redir_end", {31'b0, RedirectEn}, 32'd0);
    checkOutput("mp_upd_end", {31'b0, UpdateEn}, 32'd0);

    // Fill, then enqueue+dequeue together while full, then drain in order
    for (int i = 0; i < 4; i++) begin
      enqueue(32'h100 + 32'(4 * i), 1'b1);
      checkOutput($sformatf("fill_full_%0d", i), {31'b0, Full}, (i == 3) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 32'h110, 1'b1, 1'b1, 32'h100, 32'h0);
    exp_br++;
    checkOutput("both_full", {31'b0, Full}, 32'd1);
    checkOutput("both_err", {31'b0, Err}, 32'd0);
    checkOutput("both_upd_pc", UpdatePC, 32'h100);
    checkOutput("both_flush", {31'b0, Flush}, 32'd0);
    for (int i = 1; i < 5; i++) begin
      resolve(32'h100 + 32'(4 * i), 1'b1, 32'h0);
      exp_br++;
      checkOutput($sformatf("drain_err_%0d", i), {31'b0, Err}, 32'd0);
      checkOutput($sformatf("drain_full_%0d", i), {31'b0, Full}, 32'd0);
    end
    checkOutput("drain_br", {16'b0, BrCount}, 32'(exp_br));

    // Overflow attempt is dropped and flagged
    for (int i = 0; i < 4; i++) enqueue(32'h120 + 32'(4 * i), 1'b1);
    enqueue(32'h130, 1'b1);
    checkOutput("ovf_err", {31'b0, Err}, 32'd1);
    checkOutput("ovf_full", {31'b0, Full}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      resolve(32'h120 + 32'(4 * i), 1'b1, 32'h0);
      exp_br++;
      checkOutput($sformatf("ovf_drain_upd_%0d", i), {31'b0, UpdateEn}, 32'd1);
    end
    resolve(32'h130, 1'b1, 32'h0);
    checkOutput("ovf_dropped_upd", {31'b0, UpdateEn}, 32'd0);
    checkOutput("ovf_dropped_br", {16'b0, BrCount}, 32'(exp_br));
    checkOutput("ovf_miss", {16'b0, MissCount}, 32'(exp_miss));

    // Stalled fetch enqueues nothing, so resolution finds an empty queue
    doReset();
    StallF = 1'b1;
    enqueue(32'h300, 1'b1);
    StallF = 1'b0;
    checkOutput("stall_err", {31'b0, Err}, 32'd0);
    resolve(32'h300, 1'b1, 32'h0);
    checkOutput("empty_err", {31'b0, Err}, 32'd1);
    checkOutput("empty_upd_en", {31'b0, UpdateEn}, 32'd0);
    checkOutput("empty_br", {16'b0, BrCount}, 32'd0);

    // PC mismatch flags error but still resolves
    doReset();
    enqueue(32'h200, 1'b1);
    resolve(32'h204, 1'b1, 32'h0);
    exp_br++;
    checkOutput("pcmm_err", {31'b0, Err}, 32'd1);
    checkOutput("pcmm_upd_en", {31'b0, UpdateEn}, 32'd1);
    checkOutput("pcmm_upd_pc", UpdatePC, 32'h204);
    checkOutput("pcmm_br", {16'b0, BrCount}, 32'(exp_br));
    checkOutput("pcmm_flush", {31'b0, Flush}, 32'd0);

    // Not-taken mispredict with wrong-path enqueue in the same cycle
    enqueue(32'h40, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h50, 1'b1, 1'b0, 32'h40, 32'h999);
    exp_br++; exp_miss++;
    checkOutput("wp_flush", {31'b0, Flush}, 32'd1);
    checkOutput("wp_redir_pc", RedirectPC, 32'h44);
    checkOutput("wp_upd_taken", {31'b0, UpdateTaken}, 32'd0);
    checkOutput("wp_full", {31'b0, Full}, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h60, 1'b1, 1'b1, 32'h60, 32'h0);
    checkOutput("rec_flush_end", {31'b0, Flush}, 32'd0);
    checkOutput("rec_ignored_upd", {31'b0, UpdateEn}, 32'd0);
    checkOutput("rec_ignored_br", {16'b0, BrCount}, 32'(exp_br));
    resolve(32'h50, 1'b0, 32'h0);
    checkOutput("wp_discard_upd", {31'b0, UpdateEn}, 32'd0);
    checkOutput("wp_discard_br", {16'b0, BrCount}, 32'(exp_br));

    // Fall-through address wraps at 32 bits
    enqueue(32'hFFFF_FFFC, 1'b1);
    resolve(32'hFFFF_FFFC, 1'b0, 32'h0);
    exp_br++; exp_miss++;
    checkOutput("wrap_redir_pc", RedirectPC, 32'h0);
    checkOutput("wrap_flush", {31'b0, Flush}, 32'd1);
    idle();

    // Saturation of the 4-bit counter instance
    for (int i = 0; i < 16; i++) begin
      enqueue(32'h1000 + 32'(4 * i), 1'b1);
      resolve(32'h1000 + 32'(4 * i), 1'b1, 32'h0);
      exp_br++;
      checkOutput($sformatf("sat_br4_%0d", i), {28'b0, BrCount4}, sat4(exp_br));
    end
    checkOutput("sat_br16", {16'b0, BrCount}, 32'(exp_br));
    checkOutput("sat_miss4", {28'b0, MissCount4}, sat4(exp_miss));

    // Reset during RECOVER suppresses flush and clears everything
    enqueue(32'h2000, 1'b0);
    resolve(32'h2000, 1'b1, 32'h3000);
    checkOutput("pre_rst_flush", {31'b0, Flush}, 32'd1);
    checkOutput("pre_rst_redir_pc", RedirectPC, 32'h3000);
    doReset();
    checkOutput("rrec_flush", {31'b0, Flush}, 32'd0);
    checkOutput("rrec_redir_en", {31'b0, RedirectEn}, 32'd0);
    checkOutput("rrec_upd_en", {31'b0, UpdateEn}, 32'd0);
    checkOutput("rrec_redir_pc", RedirectPC, 32'h0);
    checkOutput("rrec_err", {31'b0, Err}, 32'd0);
    checkOutput("rrec_br", {16'b0, BrCount}, 32'd0);
    checkOutput("rrec_miss", {16'b0, MissCount}, 32'd0);
    checkOutput("rrec_br4", {28'b0, BrCount4}, 32'd0);
    checkOutput("rrec_miss4", {28'b0, MissCount4}, 32'd0);
    checkOutput("rrec_flush4", {31'b0, Flush4}, 32'd0);
    checkOutput("rrec_full4", {31'b0, Full4}, 32'd0);
    checkOutput("rrec_err4", {31'b0, Err4}, 32'd0);
    checkOutput("rrec_upd4", {31'b0, UpdateEn4}, 32'd0);
    checkOutput("rrec_updt4", {31'b0, UpdateTaken4}, 32'd0);
    checkOutput("rrec_updpc4", UpdatePC4, 32'h0);
    checkOutput("rrec_redir4", {31'b0, RedirectEn4}, 32'd0);
    checkOutput("rrec_redirpc4", RedirectPC4, 32'h0);
    idle();
    checkOutput("rrec_flush_after", {31'b0, Flush}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
